// File: rtl/key_debounce.sv
// Per-key push-button conditioner: two-flop synchroniser, polarity normalisation
// and a per-bit stability counter, with one-cycle press/release pulses.
module key_debounce #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_clean,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release
);

  localparam logic [WIDTH-1:0] RelLevel = {WIDTH{ACTIVE_LOW}};
  localparam logic [CNT_W-1:0] CntMax   = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] norm;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] release_q, release_d;

  // Normalised so that 1 always means pressed.
  assign norm = s2_q ^ RelLevel;

  always_comb begin
    cnt_d     = cnt_q;
    clean_d   = clean_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (norm[i] == clean_q[i]) begin
        // Any agreeing cycle restarts qualification, so bounce never accumulates.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        clean_d[i]   = norm[i];
        cnt_d[i]     = '0;
        press_d[i]   = norm[i];
        release_d[i] = ~norm[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= RelLevel;
      s2_q      <= RelLevel;
      clean_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= key_raw;
      s2_q      <= s1_q;
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign key_clean   = clean_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
module tb_key_debounce;

  logic       clk;
  logic       reset_n;
  logic [3:0] key_raw;
  logic [3:0] key_clean;
  logic [3:0] key_press;
  logic [3:0] key_release;

  int compared;
  int mismatched;

  key_debounce #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_raw    (key_raw),
    .key_clean  (key_clean),
    .key_press  (key_press),
    .key_release(key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] c, input logic [3:0] p,
                           input logic [3:0] r);
    check({tag, ".clean"}, key_clean, c);
    check({tag, ".press"}, key_press, p);
    check({tag, ".release"}, key_release, r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    key_raw    = 4'b1111;

    // Reset held for 3 cycles, then 20 quiet cycles.
    #1;
    for (int k = 0; k < 3; k++) begin
      check_all("reset_hold", 4'b0000, 4'b0000, 4'b0000);
      tick(1);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      check_all("reset_idle", 4'b0000, 4'b0000, 4'b0000);
    end

    // Clean press of key 0: accepted at edge 6.
    key_raw = 4'b1110;
    tick(5);
    check_all("press0_e5", 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    check_all("press0_e6", 4'b0001, 4'b0001, 4'b0000);
    tick(1);
    check_all("press0_e7", 4'b0001, 4'b0000, 4'b0000);

    // Release of key 0.
    key_raw = 4'b1111;
    tick(5);
    check_all("rel0_e5", 4'b0001, 4'b0000, 4'b0000);
    tick(1);
    check_all("rel0_e6", 4'b0000, 4'b0000, 4'b0001);
    tick(1);
    check_all("rel0_e7", 4'b0000, 4'b0000, 4'b0000);

    // Bounce on key 1: low 3, high 1, low 3, high 1, then held low.
    for (int b = 0; b < 2; b++) begin
      key_raw = 4'b1101;
      for (int k = 0; k < 3; k++) begin
        tick(1);
        check_all("bounce_lo", 4'b0000, 4'b0000, 4'b0000);
      end
      key_raw = 4'b1111;
      tick(1);
      check_all("bounce_hi", 4'b0000, 4'b0000, 4'b0000);
    end
    key_raw = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check_all("bounce_wait", 4'b0000, 4'b0000, 4'b0000);
    end
    tick(1);
    check_all("bounce_e6", 4'b0010, 4'b0010, 4'b0000);
    tick(1);
    check_all("bounce_e7", 4'b0010, 4'b0000, 4'b0000);

    // Release key 1.
    key_raw = 4'b1111;
    tick(6);
    check_all("rel1_e6", 4'b0000, 4'b0000, 4'b0010);
    tick(1);
    check_all("rel1_e7", 4'b0000, 4'b0000, 4'b0000);

    // Short glitch on key 3 (2 cycles low) is never accepted.
    key_raw = 4'b0111;
    tick(2);
    key_raw = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check_all("glitch3", 4'b0000, 4'b0000, 4'b0000);
    end

    // All keys pressed together, then released together.
    key_raw = 4'b0000;
    tick(5);
    check_all("all_e5", 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    check_all("all_e6", 4'b1111, 4'b1111, 4'b0000);
    tick(1);
    check_all("all_e7", 4'b1111, 4'b0000, 4'b0000);
    key_raw = 4'b1111;
    tick(6);
    check_all("allrel_e6", 4'b0000, 4'b0000, 4'b1111);
    tick(1);
    check_all("allrel_e7", 4'b0000, 4'b0000, 4'b0000);

    // Reset during qualification of key 2 discards progress.
    key_raw = 4'b1011;
    tick(4);
    reset_n = 1'b0;
    #1;
    check_all("midrst_assert", 4'b0000, 4'b0000, 4'b0000);
    tick(2);
    check_all("midrst_hold", 4'b0000, 4'b0000, 4'b0000);
    reset_n = 1'b1;
    tick(5);
    check_all("midrst_e5", 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    check_all("midrst_e6", 4'b0100, 4'b0100, 4'b0000);
    tick(1);
    check_all("midrst_e7", 4'b0100, 4'b0000, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Per-key input conditioner between the DE-board push-button pins and the key PIO's `in_port`. Each bit is synchronised into the `clk` domain and normalised so that 1 means pressed. A bit must hold a new level for `DEBOUNCE_CYCLES` consecutive cycles before the clean output changes. Each accepted change also produces a one-cycle press or release pulse. The PIO then sees glitch-free levels, so its edge capture fires exactly once per physical press.

## Interface
- `WIDTH`, 4: number of keys.
- `DEBOUNCE_CYCLES`, 1000000: stable cycles required before a change is accepted (20 ms at 50 MHz). Must be ≥ 2.
- `CNT_W`, 20: counter width. Must satisfy 2^CNT_W > `DEBOUNCE_CYCLES`-1.
- `ACTIVE_LOW`, 1: 1 means a raw pin reads 0 when pressed; 0 means it reads 1 when pressed.
- `clk`  in  1  system clock. Single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `key_raw`  in  `WIDTH`  raw asynchronous pin levels.
- `key_clean`  out  `WIDTH`  debounced level, 1 = pressed. Drives PIO `in_port`.
- `key_press`  out  `WIDTH`  one-cycle pulse on an accepted released→pressed change.
- `key_release`  out  `WIDTH`  one-cycle pulse on an accepted pressed→released change.

## Operation
- Per bit i, three stages:
  - Two-flop synchroniser: `s1[i]` then `s2[i]`.
  - Polarity normalisation: `n[i]` = `s2[i]` XOR `ACTIVE_LOW`.
  - Debounce counter `cnt[i]` plus registered `key_clean[i]`.
- Counter rule, evaluated every rising edge per bit:
  - `n[i]` == `key_clean[i]`: `cnt[i]` <= 0; no output change.
  - `n[i]` != `key_clean[i]` and `cnt[i]` < `DEBOUNCE_CYCLES`-1: `cnt[i]` <= `cnt[i]`+1.
  - `n[i]` != `key_clean[i]` and `cnt[i]` == `DEBOUNCE_CYCLES`-1: `key_clean[i]` <= `n[i]`; `cnt[i]` <= 0. Pulse `key_press[i]` if `n[i]`=1, otherwise `key_release[i]`.
- A pulse is high for exactly the one cycle after the edge where `key_clean[i]` changes. It deasserts on the next edge.
- Any single cycle in which `n[i]` matches `key_clean[i]` restarts qualification. Bounce therefore never accumulates across glitches.
- Bits are fully independent. Simultaneous changes on several bits are accepted on their own schedules. Several pulse bits may be high in the same cycle.
- Counter never wraps: the maximum value reached is `DEBOUNCE_CYCLES`-1.
- Reset values (asynchronous assertion):
  - `s1`, `s2`: released level (all 1 when `ACTIVE_LOW`=1, otherwise 0).
  - `cnt`: 0.
  - `key_clean`, `key_press`, `key_release`: 0.
- Reset mid-qualification discards progress. A key still held after reset release must re-qualify in full.

## Timing
- Latency: `key_clean[i]` changes at rising edge number `DEBOUNCE_CYCLES`+2 after `key_raw[i]` changes, where edge 1 is the first edge that samples the new level into `s1`. The raw level must be stable throughout. The pulse appears in the same cycle.
- A raw pulse or glitch lasting fewer than `DEBOUNCE_CYCLES` cycles at `s2` is never accepted.
- No handshake. Outputs are registered and valid every cycle.
- `key_raw` may change at any time. Metastability is confined to `s1`.

## Test plan
Bench parameters for all scenarios: `WIDTH`=4, `DEBOUNCE_CYCLES`=4, `ACTIVE_LOW`=1.
- **Reset:** `key_raw`=4'b1111, `reset_n` low for 3 cycles then released → `key_clean`=0, `key_press`=0 and `key_release`=0, both during reset and for 20 cycles after.
- **Clean press:** `key_raw[0]` 1→0 just before edge 1 and held → `key_clean[0]`=1 after edge 6. `key_press`=4'b0001 for exactly that cycle. `key_release` stays 0.
- **Bounce rejection:** `key_raw[1]` low 3 cycles, high 1, low 3, high 1, then low and held → no change until 6 edges after the final fall. Then a single `key_press[1]` pulse.
- **Release:** from `key_clean`=4'b0001, `key_raw[0]` returns to 1 → `key_clean[0]`=0 after 6 edges and `key_release`=4'b0001 for one cycle.
- **Simultaneous keys:** `key_raw` 4'b1111→4'b0000 in one cycle → `key_clean`=4'b1111 and `key_press`=4'b1111 together after edge 6.
- **Reset mid-count:** `key_raw[2]` low, `reset_n` pulsed low after edge 4 while low is held → `key_clean[2]`=0 through reset. After release, `key_clean[2]`=1 six edges after the first post-reset edge.
